prog_instr_mem: RTL and testbench
=================================

PROG_INSTR_MEM -- requirements
Module: prog_instr_mem

Interface
REQ-001 Parameter DATA_W, default 16, is the instruction width in bits and SHALL be an even multiple of 8.
REQ-002 Parameter DEPTH, default 64, is the number of instruction words stored.
REQ-003 Parameter ADDR_W, default 16, is the byte-address width of the fetch port.
REQ-004 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address of the instruction.
- fetch_instr  out  DATA_W  registered instruction word.
- fetch_valid  out  1  fetch_instr valid this cycle.
- fetch_fault  out  1  the last fetch was misaligned or out of range.
- load_start  in  1  begin a program load.
- load_valid  in  1  load_byte present.
- load_byte  in  8  program byte, most significant byte first.
- load_last  in  1  final byte of the program.
- load_ready  out  1  block accepts load_byte.
- load_done  out  1  one-cycle pulse when a load completes.
- busy  out  1  load in progress; fetches are refused.

Function
REQ-005 Word index SHALL be fetch_addr[ADDR_W-1:1] and byte addressing SHALL be word-aligned on even addresses.
REQ-006 Fetch latency SHALL be 1 cycle: fetch_req accepted at edge N gives fetch_valid=1 and fetch_instr during cycle N+1.
REQ-007 A fetch with fetch_addr[0]=1 or word index >= DEPTH SHALL return fetch_instr=0, fetch_valid=1 and fetch_fault=1.
REQ-008 A valid in-range fetch SHALL set fetch_fault=0.
REQ-009 When fetch_req=0, or busy=1, at the edge, fetch_valid SHALL be 0 next cycle and fetch_instr SHALL hold its previous value.
REQ-010 The load FSM SHALL have states IDLE, BYTE, COMMIT and DONE.
REQ-011 IDLE -> BYTE SHALL occur on load_start=1; this clears the write pointer and byte counter.
REQ-012 In BYTE, load_ready SHALL be 1 and each byte is accepted when load_valid=1 and load_ready=1.
REQ-013 Bytes SHALL be packed MSB first into a DATA_W assembly register.
REQ-014 BYTE -> COMMIT SHALL occur after DATA_W/8 bytes are accepted, or when load_last=1 arrives with an accepted byte.
REQ-015 On a partial word, the unfilled low bytes SHALL be 0.
REQ-016 In COMMIT (one cycle, load_ready=0), the assembled word SHALL be written at the write pointer and the pointer incremented.
REQ-017 COMMIT SHALL go to DONE if load_last was seen or the pointer reaches DEPTH; otherwise it SHALL return to BYTE.
REQ-018 DONE SHALL assert load_done for exactly one cycle and then return to IDLE.
REQ-019 busy SHALL be 1 in BYTE, COMMIT and DONE, and 0 in IDLE.
REQ-020 load_start SHALL be ignored outside IDLE.
REQ-021 load_valid SHALL be ignored outside BYTE.
REQ-022 Words not written by a load SHALL retain their prior contents.
REQ-023 When fetch_req and load_start are both high in IDLE, the fetch SHALL complete normally and the load SHALL start in the same edge.

Reset
REQ-024 Asserting rst SHALL at any time, including mid-load, force the FSM to IDLE.
REQ-025 Reset values SHALL be:
- all memory words 0 (NOP);
- write pointer 0;
- fetch_instr 0;
- fetch_valid, fetch_fault, load_ready, load_done and busy all 0.
REQ-026 The first fetch SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-027 Load FSM state encodings and the NOP constant (0) SHALL reside in the shared processor package.
REQ-028 The byte-packing assembler (shift register plus byte counter) SHALL be one sub-module named instr_byte_packer.
REQ-029 Storage SHALL be a DEPTH x DATA_W register array with a single write port and a single read port.

Verification
REQ-030 Reset then fetch_addr=0x0000 -> fetch_instr=0x0000, fetch_valid=1 and fetch_fault=0 one cycle later.
REQ-031 Load bytes 40,10,52,30 (last on 30) -> load_done pulses, word0=0x4010 and word1=0x5230; fetch 0x0002 -> 0x5230.
REQ-032 Fetch 0x0003 -> fault=1 and instr=0; fetch 0x0080 with DEPTH=64 -> fault=1.
REQ-033 Load byte 0xAB with load_last=1 -> word0=0xAB00; word1 is unchanged.
REQ-034 Fetch during a load -> fetch_valid=0; load_valid gaps between bytes stall the load without data loss.
REQ-035 rst asserted after 3 of 4 bytes -> FSM IDLE, all words 0, busy=0; a subsequent full load succeeds.

Source files
------------

// File: rtl/prog_instr_mem_pkg.sv
// Shared processor definitions: load FSM state encodings and the NOP instruction value.
package prog_instr_mem_pkg;

  typedef enum logic [1:0] {
    LOAD_IDLE   = 2'd0,
    LOAD_BYTE   = 2'd1,
    LOAD_COMMIT = 2'd2,
    LOAD_DONE   = 2'd3
  } load_state_e;

  localparam int unsigned NOP = 0;

endpackage

// File: rtl/instr_byte_packer.sv
// Assembles program bytes, most significant first, into one instruction word.
module instr_byte_packer
  import prog_instr_mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              last_slot_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = $clog2(BYTES + 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (clear_i) begin
      shift_d = DATA_W'(NOP);
      count_d = '0;
    end else if (push_i) begin
      shift_d = {shift_q[DATA_W-9:0], byte_i};
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= DATA_W'(NOP);
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  // Left-justify a partial word so the unfilled low bytes read as zero.
  assign word_o      = shift_q << (8 * (BYTES - int'(count_q)));
  assign last_slot_o = (count_q == CNT_W'(BYTES - 1));

endmodule

// File: rtl/prog_instr_mem.sv
// Instruction memory with a one-cycle fetch port and a byte-serial program loader.
module prog_instr_mem
  import prog_instr_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = ADDR_W - 1;

  load_state_e       state_q, state_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic              last_seen_q, last_seen_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] instr_q;
  logic              valid_q, fault_q;

  logic              pack_clear, pack_push, pack_last_slot, mem_we;
  logic [DATA_W-1:0] pack_word;
  logic [IDX_W-1:0]  fetch_idx;
  logic              fetch_bad;

  instr_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (pack_clear),
    .push_i      (pack_push),
    .byte_i      (load_byte),
    .word_o      (pack_word),
    .last_slot_o (pack_last_slot)
  );

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    last_seen_d = last_seen_q;
    pack_clear  = 1'b0;
    pack_push   = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      LOAD_IDLE: begin
        if (load_start) begin
          state_d     = LOAD_BYTE;
          wptr_d      = '0;
          last_seen_d = 1'b0;
          pack_clear  = 1'b1;
        end
      end
      LOAD_BYTE: begin
        if (load_valid) begin
          pack_push   = 1'b1;
          last_seen_d = load_last;
          if (load_last || pack_last_slot) state_d = LOAD_COMMIT;
        end
      end
      LOAD_COMMIT: begin
        mem_we     = 1'b1;
        wptr_d     = wptr_q + PTR_W'(1);
        pack_clear = 1'b1;
        if (last_seen_q || wptr_q == PTR_W'(DEPTH - 1)) state_d = LOAD_DONE;
        else                                            state_d = LOAD_BYTE;
      end
      LOAD_DONE: state_d = LOAD_IDLE;
      default:   state_d = LOAD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD_IDLE;
      wptr_q      <= '0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      last_seen_q <= last_seen_d;
    end
  end

  // Reset clears every word so an unloaded program executes NOPs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(NOP);
    end else if (mem_we) begin
      mem_q[wptr_q] <= pack_word;
    end
  end

  assign fetch_idx = fetch_addr[ADDR_W-1:1];
  assign fetch_bad = fetch_addr[0] || (fetch_idx >= IDX_W'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= DATA_W'(NOP);
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (fetch_req && !busy) begin
      valid_q <= 1'b1;
      fault_q <= fetch_bad;
      instr_q <= fetch_bad ? DATA_W'(NOP) : mem_q[fetch_idx[PTR_W-1:0]];
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign fetch_instr = instr_q;
  assign fetch_valid = valid_q;
  assign fetch_fault = fault_q;
  assign load_ready  = (state_q == LOAD_BYTE);
  assign load_done   = (state_q == LOAD_DONE);
  assign busy        = (state_q != LOAD_IDLE);

endmodule

// File: tb/tb_prog_instr_mem.sv
// Scoreboard bench for prog_instr_mem: random loads and fetches against an array model.
module tb_prog_instr_mem;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_valid, fetch_fault;
  logic              load_start, load_valid, load_last;
  logic [7:0]        load_byte;
  logic              load_ready, load_done, busy;

  typedef struct packed {
    logic [15:0] instr;
    logic        fault;
  } exp_t;

  exp_t        expQ[$];
  logic [7:0]  bytesQ[$];
  logic [15:0] model_mem [DEPTH];
  logic [15:0] last_instr = 16'h0000;
  int          checks = 0;
  int          failures = 0;

  prog_instr_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .fetch_valid (fetch_valid),
    .fetch_fault (fetch_fault),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t expectFetch(input logic [15:0] addr);
    exp_t e;
    int   idx;
    idx = int'(addr >> 1);
    if (addr[0] || idx >= DEPTH) begin
      e.instr = 16'h0000;
      e.fault = 1'b1;
    end else begin
      e.instr = model_mem[idx];
      e.fault = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [15:0] randAddr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 16'($urandom_range(0, DEPTH - 1) * 2);
    else if (r == 7) return 16'($urandom_range(0, DEPTH - 1) * 2 + 1);
    else if (r == 8) return 16'($urandom_range(DEPTH * 2, 65535));
    else             return 16'($urandom);
  endfunction

  // Behavioural view of a completed load: byte pairs become words from index 0 upward.
  task automatic commitModel();
    int n;
    n = bytesQ.size();
    for (int w = 0; w * 2 < n && w < DEPTH; w++)
      model_mem[w] = {bytesQ[2 * w], (2 * w + 1 < n) ? bytesQ[2 * w + 1] : 8'h00};
  endtask

  task automatic clearModel();
    for (int w = 0; w < DEPTH; w++) model_mem[w] = 16'h0000;
  endtask

  // Called at a negedge; issues one fetch and records what it must return.
  task automatic fetchOne(input logic [15:0] addr);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    expQ.push_back(expectFetch(addr));
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  // Streams bytesQ into the loader with random gaps; stops early after nSend bytes.
  task automatic applyStimulus(input bit useLast, input int nSend, input bit fetchWithStart,
                               input logic [15:0] startAddr);
    int  tries;
    bit  found;
    load_start = 1'b1;
    if (fetchWithStart) begin
      fetch_req  = 1'b1;
      fetch_addr = startAddr;
      expQ.push_back(expectFetch(startAddr));
    end
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 16'h0002;
    @(posedge clk);
    #1 checkOutput("fetch_valid_while_busy", 32'(fetch_valid), 32'd0);
    @(negedge clk);
    fetch_req = 1'b0;
    for (int i = 0; i < nSend; i++) begin
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'b0;
        load_start = 1'b0;
        @(negedge clk);
      end
      tries = 0;
      while (!load_ready && tries < 10) begin
        load_valid = 1'b1;
        load_byte  = 8'hEE;
        load_last  = 1'b1;
        @(negedge clk);
        tries++;
      end
      if (tries >= 10) begin
        checkOutput("load_ready_timeout", 32'(load_ready), 32'd1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        return;
      end
      load_valid = 1'b1;
      load_start = (i > 0);
      load_byte  = bytesQ[i];
      load_last  = useLast && (i == bytesQ.size() - 1);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_start = 1'b0;
    if (nSend < bytesQ.size()) return;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk);
      #1 if (load_done) found = 1'b1;
    end
    checkOutput("load_done_seen", 32'(found), 32'd1);
    if (found) begin
      commitModel();
      @(posedge clk);
      #1;
      checkOutput("load_done_one_cycle", 32'(load_done), 32'd0);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
    end
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per valid fetch, and checks the held word otherwise.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst) begin
      last_instr = 16'h0000;
    end else if (fetch_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("fetch_valid_spurious", 32'(fetch_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("fetch_instr", 32'(fetch_instr), 32'(e.instr));
        checkOutput("fetch_fault", 32'(fetch_fault), 32'(e.fault));
        last_instr = e.instr;
      end
    end else begin
      checkOutput("fetch_instr_hold", 32'(fetch_instr), 32'(last_instr));
    end
  end

  initial begin
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_byte  = 8'h00;
    load_last  = 1'b0;
    clearModel();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_fetch_instr", 32'(fetch_instr), 32'd0);
    checkOutput("reset_fetch_valid", 32'(fetch_valid), 32'd0);
    checkOutput("reset_fetch_fault", 32'(fetch_fault), 32'd0);
    checkOutput("reset_load_ready", 32'(load_ready), 32'd0);
    checkOutput("reset_load_done", 32'(load_done), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    // First fetch lands on the first edge after reset release.
    rst = 1'b1;
    fetchOne(16'h0000);

    bytesQ = '{8'h40, 8'h10, 8'h52, 8'h30};
    applyStimulus(1'b1, 4, 1'b0, 16'h0000);
    fetchOne(16'h0000);
    fetchOne(16'h0002);
    fetchOne(16'h0003);
    fetchOne(16'h0080);

    // Single-byte load with a fetch issued on the same edge as load_start.
    bytesQ = '{8'hAB};
    applyStimulus(1'b1, 1, 1'b1, 16'h0002);
    fetchOne(16'h0000);
    fetchOne(16'h0002);

    repeat (6) begin
      int n;
      n = int'($urandom_range(1, 9));
      bytesQ.delete();
      for (int i = 0; i < n; i++) bytesQ.push_back(8'($urandom));
      applyStimulus(1'b1, n, 1'($urandom_range(0, 1)), randAddr());
      repeat (8) fetchOne(randAddr());
    end

    // Reset in the middle of a four-byte load.
    bytesQ.delete();
    for (int i = 0; i < 4; i++) bytesQ.push_back(8'($urandom_range(1, 255)));
    applyStimulus(1'b1, 3, 1'b0, 16'h0000);
    rst = 1'b0;
    #1;
    checkOutput("midload_reset_busy", 32'(busy), 32'd0);
    checkOutput("midload_reset_ready", 32'(load_ready), 32'd0);
    checkOutput("midload_reset_instr", 32'(fetch_instr), 32'd0);
    clearModel();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fetchOne(16'h0000);
    fetchOne(16'h0002);
    fetchOne(16'h0004);
    applyStimulus(1'b1, 4, 1'b0, 16'h0000);
    fetchOne(16'h0000);
    fetchOne(16'h0002);

    // Full-depth load without load_last ends when the pointer reaches DEPTH.
    bytesQ.delete();
    for (int i = 0; i < DEPTH * 2; i++) bytesQ.push_back(8'($urandom));
    applyStimulus(1'b0, DEPTH * 2, 1'b0, 16'h0000);
    fetchOne(16'(DEPTH * 2 - 2));
    repeat (20) fetchOne(randAddr());

    repeat (3) @(posedge clk);
    #2 checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
